operand_fetch_unit: RTL and testbench
=====================================

// Module: operand_fetch_unit
// PURPOSE
// Register-read stage; the read-side counterpart of the write-back stage. Owns the
// 32x32 register file. The write-back stage drives its write port. Decodes source
// fields, reads two operands with same-cycle bypass from write-back, and registers
// instruction, PC and operands into the pipeline register feeding execute.
// Supports stall (hold) and flush (insert bubble).
// PARAMETERS
// WIDTH            32            datapath/register width
// NOP_INSTRUCTION  32'hFFFFFFFF  bubble: opcode 6'b111111, no reg write, not halt
// PORTS
// clock_i              in   1      clock; all state updates on rising edge
// reset_n_i            in   1      async active-low reset
// instruction_i        in   32     instruction from decode/fetch
// pc_i                 in   WIDTH  PC associated with instruction_i
// stall_i              in   1      hold pipeline register contents
// flush_i              in   1      replace captured instruction with bubble
// write_reg_i          in   WIDTH  write-back data
// select_write_reg_i   in   5      write-back destination index
// reg_write_enable_i   in   1      write-back write strobe
// instruction_o        out  32     registered instruction to execute
// pc_o                 out  WIDTH  registered PC
// operand1_o           out  WIDTH  registered source A value
// operand2_o           out  WIDTH  registered source B / store-data value
// BEHAVIOUR
// - Reset (reset_n_i=0, async): all 32 registers <= 0; instruction_o <= NOP_INSTRUCTION;
//   pc_o, operand1_o, operand2_o <= 0. Reset mid-operation discards all in-flight state.
// - Opcode = instruction_i[31:26]. srcA = [20:16]. srcB = [15:11], except stores
//   (opcode[5:3]==3'b101): srcB = [25:21] (store data).
// - Write port: on clock edge with reg_write_enable_i=1, reg[select_write_reg_i] <= write_reg_i.
//   Index 31 is the PC and is never stored; a write to index 31 is ignored.
// - Read value(idx): idx==31 -> pc_i.
//   Else if reg_write_enable_i && select_write_reg_i==idx -> write_reg_i (bypass).
//   Else reg[idx].
// - Latency: 1 cycle. An instruction presented at edge N appears on the *_o outputs
//   after edge N.
// - Priority each edge: flush_i > stall_i > normal.
//   flush: instruction_o <= NOP_INSTRUCTION, pc_o <= 0, operands <= 0.
//   stall: instruction_o and pc_o hold. Each held operand is patched: if
//     reg_write_enable_i and select_write_reg_i equals that operand's source index
//     (decoded from instruction_o, and != 31), the operand <= write_reg_i; otherwise
//     it holds. This keeps stalled operands coherent.
//   normal: capture instruction_i, pc_i, and Read(srcA), Read(srcB).
// - Register-file writes happen regardless of stall or flush.
// - srcA==srcB: both operands receive the identical, bypassed value.
// - No internal state machine beyond the pipeline register and register array; no
//   combinational path from *_i to *_o.
// TESTING
// 1 Reset: assert reset_n_i mid-run -> outputs immediately NOP/0/0/0; any register
//   read after release returns 0.
// 2 Write r5=32'h1234 with the cycle idle, then issue instruction srcA=5 -> operand1_o
//   = 32'h1234 one cycle later.
// 3 Bypass: in the same cycle, write r7=32'hCAFE and issue srcA=7, srcB=7 ->
//   operand1_o = operand2_o = 32'hCAFE.
// 4 PC read: srcA=31 with pc_i=32'h400 -> operand1_o = 32'h400. A write to 31 leaves
//   no stored state.
// 5 Stall patch: stall_i=1 holding srcB=3; write r3=32'hBEEF -> operand2_o = 32'hBEEF
//   and instruction_o unchanged.
// 6 Flush with stall both high -> instruction_o = 32'hFFFFFFFF, operands 0; a store
//   then reads [25:21] into operand2_o.

Source files
------------

// File: rtl/operand_fetch_unit.sv
// Register-read stage: owns the 32-entry register file (index 31 aliases the PC),
// reads two source operands with same-cycle bypass from write-back, and registers
// instruction, PC and operands for the execute stage. Supports stall and flush.
module operand_fetch_unit #(
    parameter int unsigned  WIDTH           = 32,
    parameter logic [31:0]  NOP_INSTRUCTION = 32'hFFFFFFFF
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic [31:0]      instruction_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] write_reg_i,
    input  logic [4:0]       select_write_reg_i,
    input  logic             reg_write_enable_i,
    output logic [31:0]      instruction_o,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] operand1_o,
    output logic [WIDTH-1:0] operand2_o
);

    localparam logic [4:0] PC_INDEX = 5'd31;

    // Only indices 0..30 are physical; index 31 reads back the PC.
    logic [WIDTH-1:0] r_regs [0:30];

    logic [31:0]      r_instruction;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_operand1;
    logic [WIDTH-1:0] r_operand2;

    logic [4:0]       w_src_a;
    logic [4:0]       w_src_b;
    logic [4:0]       w_held_src_a;
    logic [4:0]       w_held_src_b;
    logic [WIDTH-1:0] w_read_a;
    logic [WIDTH-1:0] w_read_b;
    logic [WIDTH-1:0] w_patch_a;
    logic [WIDTH-1:0] w_patch_b;
    logic             w_rf_write;

    assign w_rf_write = reg_write_enable_i && (select_write_reg_i != PC_INDEX);

    // Decode source indices for the incoming and the held instruction; stores take
    // operand B from [25:21] (store data).
    always_comb begin
        w_src_a      = instruction_i[20:16];
        w_src_b      = instruction_i[15:11];
        w_held_src_a = r_instruction[20:16];
        w_held_src_b = r_instruction[15:11];
        if (instruction_i[31:29] == 3'b101) begin
            w_src_b = instruction_i[25:21];
        end
        if (r_instruction[31:29] == 3'b101) begin
            w_held_src_b = r_instruction[25:21];
        end
    end

    // Operand read with PC aliasing and write-back bypass.
    always_comb begin
        w_read_a = '0;
        w_read_b = '0;
        if (w_src_a == PC_INDEX) begin
            w_read_a = pc_i;
        end else if (reg_write_enable_i && (select_write_reg_i == w_src_a)) begin
            w_read_a = write_reg_i;
        end else begin
            w_read_a = r_regs[w_src_a];
        end
        if (w_src_b == PC_INDEX) begin
            w_read_b = pc_i;
        end else if (reg_write_enable_i && (select_write_reg_i == w_src_b)) begin
            w_read_b = write_reg_i;
        end else begin
            w_read_b = r_regs[w_src_b];
        end
    end

    // Stalled operands pick up a write-back to their own source so they stay coherent.
    always_comb begin
        w_patch_a = r_operand1;
        w_patch_b = r_operand2;
        if (w_rf_write && (select_write_reg_i == w_held_src_a)) begin
            w_patch_a = write_reg_i;
        end
        if (w_rf_write && (select_write_reg_i == w_held_src_b)) begin
            w_patch_b = write_reg_i;
        end
    end

    // Register file write port; writes proceed regardless of stall or flush.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < 31; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_rf_write) begin
            r_regs[select_write_reg_i] <= write_reg_i;
        end
    end

    // Pipeline register toward execute: flush beats stall beats normal capture.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_instruction <= NOP_INSTRUCTION;
            r_pc          <= '0;
            r_operand1    <= '0;
            r_operand2    <= '0;
        end else if (flush_i) begin
            r_instruction <= NOP_INSTRUCTION;
            r_pc          <= '0;
            r_operand1    <= '0;
            r_operand2    <= '0;
        end else if (stall_i) begin
            r_operand1    <= w_patch_a;
            r_operand2    <= w_patch_b;
        end else begin
            r_instruction <= instruction_i;
            r_pc          <= pc_i;
            r_operand1    <= w_read_a;
            r_operand2    <= w_read_b;
        end
    end

    assign instruction_o = r_instruction;
    assign pc_o          = r_pc;
    assign operand1_o    = r_operand1;
    assign operand2_o    = r_operand2;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Scoreboard bench for operand_fetch_unit: a driver applies directed vectors and
// queues hand-computed expectations; a monitor compares after each rising edge.
module tb_operand_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction_i = 32'hFFFFFFFF;
    logic [31:0] pc_i = '0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] write_reg_i = '0;
    logic [4:0]  select_write_reg_i = '0;
    logic        reg_write_enable_i = 1'b0;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic [31:0] operand1_o;
    logic [31:0] operand2_o;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    localparam logic [31:0] NOP = 32'hFFFFFFFF;
    localparam logic [5:0]  OP_ALU = 6'b000000;
    localparam logic [5:0]  OP_ST  = 6'b101000;

    typedef struct {
        bit          chk;
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        string       name;
    } exp_t;

    exp_t sb[$];

    operand_fetch_unit #(
        .WIDTH(32),
        .NOP_INSTRUCTION(32'hFFFFFFFF)
    ) dut (
        .clock_i(clk),
        .reset_n_i(rst_n),
        .instruction_i(instruction_i),
        .pc_i(pc_i),
        .stall_i(stall_i),
        .flush_i(flush_i),
        .write_reg_i(write_reg_i),
        .select_write_reg_i(select_write_reg_i),
        .reg_write_enable_i(reg_write_enable_i),
        .instruction_o(instruction_o),
        .pc_o(pc_o),
        .operand1_o(operand1_o),
        .operand2_o(operand2_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] f25,
                                       input logic [4:0] sa, input logic [4:0] sb_idx);
        return {op, f25, sa, sb_idx, 11'd0};
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Apply one cycle of inputs (starting at a falling edge) and queue its expectation.
    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic st, input logic fl,
                         input logic we, input logic [4:0] wi, input logic [31:0] wd,
                         input bit chk, input logic [31:0] ei, input logic [31:0] ep,
                         input logic [31:0] ea, input logic [31:0] eb, input string nm);
        exp_t e;
        instruction_i      = ins;
        pc_i               = pc;
        stall_i            = st;
        flush_i            = fl;
        reg_write_enable_i = we;
        select_write_reg_i = wi;
        write_reg_i        = wd;
        e.chk = chk; e.ins = ei; e.pc = ep; e.a = ea; e.b = eb; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: the pipeline register updates every edge, so each edge retires one entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    cmp({e.name, ".instr"}, instruction_o, e.ins);
                    cmp({e.name, ".pc"},    pc_o,          e.pc);
                    cmp({e.name, ".op1"},   operand1_o,    e.a);
                    cmp({e.name, ".op2"},   operand2_o,    e.b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] i_held;
        logic [31:0] i_st;

        // Power-on reset
        #12;
        cmp("por.instr", instruction_o, NOP);
        cmp("por.op1",   operand1_o,    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle cycle writing r5; a NOP reads index 31 (PC=0) on both sides
        drive(NOP, 32'h0, 0, 0, 1, 5'd5, 32'h1234, 1, NOP, 32'h0, 32'h0, 32'h0, "idle_wr");
        drive(mk(OP_ALU, 5'd0, 5'd5, 5'd0), 32'h100, 0, 0, 0, 5'd0, 32'h0,
              1, mk(OP_ALU, 5'd0, 5'd5, 5'd0), 32'h100, 32'h1234, 32'h0, "read_r5");
        // Same-cycle bypass, srcA==srcB
        drive(mk(OP_ALU, 5'd0, 5'd7, 5'd7), 32'h104, 0, 0, 1, 5'd7, 32'hCAFE,
              1, mk(OP_ALU, 5'd0, 5'd7, 5'd7), 32'h104, 32'hCAFE, 32'hCAFE, "bypass");
        // PC read plus a write to index 31
        drive(mk(OP_ALU, 5'd0, 5'd31, 5'd5), 32'h400, 0, 0, 1, 5'd31, 32'hDEAD,
              1, mk(OP_ALU, 5'd0, 5'd31, 5'd5), 32'h400, 32'h400, 32'h1234, "pc_read");
        drive(mk(OP_ALU, 5'd0, 5'd31, 5'd31), 32'h408, 0, 0, 0, 5'd0, 32'h0,
              1, mk(OP_ALU, 5'd0, 5'd31, 5'd31), 32'h408, 32'h408, 32'h408, "pc_both");

        // Stall patching
        i_held = mk(OP_ALU, 5'd0, 5'd2, 5'd3);
        drive(i_held, 32'h500, 0, 0, 0, 5'd0, 32'h0, 1, i_held, 32'h500, 32'h0, 32'h0, "pre_stall");
        drive(mk(OP_ALU, 5'd1, 5'd1, 5'd1), 32'h504, 1, 0, 1, 5'd3, 32'hBEEF,
              1, i_held, 32'h500, 32'h0, 32'hBEEF, "stall_patch_b");
        drive(mk(OP_ALU, 5'd1, 5'd1, 5'd1), 32'h504, 1, 0, 1, 5'd2, 32'h2222,
              1, i_held, 32'h500, 32'h2222, 32'hBEEF, "stall_patch_a");
        drive(mk(OP_ALU, 5'd1, 5'd1, 5'd1), 32'h504, 1, 0, 1, 5'd9, 32'h9999,
              1, i_held, 32'h500, 32'h2222, 32'hBEEF, "stall_hold");
        drive(mk(OP_ALU, 5'd0, 5'd3, 5'd9), 32'h508, 0, 0, 0, 5'd0, 32'h0,
              1, mk(OP_ALU, 5'd0, 5'd3, 5'd9), 32'h508, 32'hBEEF, 32'h9999, "post_stall");

        // Flush wins over stall; register write still lands
        drive(mk(OP_ALU, 5'd0, 5'd1, 5'd1), 32'h600, 1, 1, 1, 5'd4, 32'h4444,
              1, NOP, 32'h0, 32'h0, 32'h0, "flush_stall");
        i_st = mk(OP_ST, 5'd4, 5'd5, 5'd7);
        drive(i_st, 32'h604, 0, 0, 0, 5'd0, 32'h0, 1, i_st, 32'h604, 32'h1234, 32'h4444, "store_rd");
        i_st = mk(OP_ST, 5'd6, 5'd5, 5'd7);
        drive(i_st, 32'h608, 0, 0, 1, 5'd6, 32'h66, 1, i_st, 32'h608, 32'h1234, 32'h66, "store_byp");
        // Held store patches via [25:21], not via [15:11]
        drive(NOP, 32'h0, 1, 0, 1, 5'd6, 32'h77, 1, i_st, 32'h608, 32'h1234, 32'h77, "st_stall_patch");
        drive(NOP, 32'h0, 1, 0, 1, 5'd7, 32'h99, 1, i_st, 32'h608, 32'h1234, 32'h77, "st_stall_nopatch");

        // A stalled PC-sourced operand ignores writes to 31
        drive(mk(OP_ALU, 5'd0, 5'd31, 5'd1), 32'h700, 0, 0, 0, 5'd0, 32'h0,
              1, mk(OP_ALU, 5'd0, 5'd31, 5'd1), 32'h700, 32'h700, 32'h0, "pc_pre_stall");
        drive(NOP, 32'h0, 1, 0, 1, 5'd31, 32'hAAAA,
              1, mk(OP_ALU, 5'd0, 5'd31, 5'd1), 32'h700, 32'h700, 32'h0, "pc_stall_w31");

        // Mid-run asynchronous reset
        rst_n = 1'b0;
        #1;
        cmp("rst.instr", instruction_o, NOP);
        cmp("rst.pc",    pc_o,          32'h0);
        cmp("rst.op1",   operand1_o,    32'h0);
        cmp("rst.op2",   operand2_o,    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(OP_ALU, 5'd0, 5'd5, 5'd7), 32'h10, 0, 0, 0, 5'd0, 32'h0,
              1, mk(OP_ALU, 5'd0, 5'd5, 5'd7), 32'h10, 32'h0, 32'h0, "rst_read57");
        drive(mk(OP_ALU, 5'd0, 5'd3, 5'd6), 32'h14, 0, 0, 0, 5'd0, 32'h0,
              1, mk(OP_ALU, 5'd0, 5'd3, 5'd6), 32'h14, 32'h0, 32'h0, "rst_read36");

        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(negedge clk);
        end
        if (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
